// File: rtl/inst_axi_bridge_pkg.sv
// Shared AXI constants and types for the instruction-fetch SRAM-to-AXI read bridge.
package inst_axi_bridge_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] FETCH_ARID = 4'd0;

    typedef enum logic [0:0] {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_e;

    // SRAM size code maps straight onto AXI arsize once zero-extended.
    function automatic logic [2:0] size_to_arsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/inst_axi_bridge_if.sv
// Fetch-side SRAM-like handshake plus AXI AR/R channels seen by the bridge.
interface inst_axi_bridge_if;

    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_rerr;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_sram_rerr,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_sram_rerr,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/inst_axi_bridge.sv
// Instruction-fetch bridge: turns SRAM-like fetch requests into single-beat AXI reads,
// holding one address at a time and tracking up to MAX_OUTST returns in flight.
module inst_axi_bridge
    import inst_axi_bridge_pkg::*;
#(
    parameter logic [3:0] ARID      = FETCH_ARID,
    parameter int         MAX_OUTST = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    inst_axi_bridge_if.master    bus
);

    localparam int                 OUTST_W   = $clog2(MAX_OUTST + 1);
    localparam logic [OUTST_W-1:0] OUTST_MAX = OUTST_W'(MAX_OUTST);
    localparam logic [OUTST_W-1:0] OUTST_ONE = {{(OUTST_W-1){1'b0}}, 1'b1};
    localparam logic [OUTST_W-1:0] OUTST_ZERO = {OUTST_W{1'b0}};

    ar_state_e          state_r;
    ar_state_e          state_nxt_s;
    logic [OUTST_W-1:0] outst_r;
    logic [31:0]        araddr_r;
    logic [2:0]         arsize_r;
    logic               addr_ok_s;
    logic               data_ok_s;
    logic               rready_s;
    logic               inc_s;
    logic               dec_s;
    logic               unused_ok_s;

    assign rready_s    = 1'b1;
    assign unused_ok_s = &{1'b0, bus.inst_sram_wr, bus.rid};

    // Acceptance and return qualification; both forced low while reset is held.
    always_comb begin
        addr_ok_s = 1'b0;
        data_ok_s = 1'b0;
        inc_s     = 1'b0;
        dec_s     = 1'b0;
        if (reset) begin
            addr_ok_s = 1'b0;
            data_ok_s = 1'b0;
        end else begin
            addr_ok_s = bus.inst_sram_req && (state_r == AR_IDLE) && (outst_r < OUTST_MAX);
            data_ok_s = bus.rvalid && (outst_r != OUTST_ZERO);
            inc_s     = addr_ok_s;
            // Stray beats with nothing outstanding are swallowed without a count change.
            dec_s     = bus.rvalid && rready_s && bus.rlast && (outst_r != OUTST_ZERO);
        end
    end

    // AR channel next-state: hold the address until the slave takes it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            AR_IDLE: begin
                if (addr_ok_s) begin
                    state_nxt_s = AR_BUSY;
                end else begin
                    state_nxt_s = AR_IDLE;
                end
            end
            AR_BUSY: begin
                if (bus.arready) begin
                    state_nxt_s = AR_IDLE;
                end else begin
                    state_nxt_s = AR_BUSY;
                end
            end
            default: state_nxt_s = AR_IDLE;
        endcase
    end

    // AR state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= AR_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Address/size holding register, loaded only on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            araddr_r <= 32'd0;
            arsize_r <= 3'd0;
        end else if (addr_ok_s) begin
            araddr_r <= bus.inst_sram_addr;
            arsize_r <= size_to_arsize(bus.inst_sram_size);
        end
    end

    // Outstanding-fetch counter; a same-cycle accept and return cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            outst_r <= OUTST_ZERO;
        end else begin
            case ({inc_s, dec_s})
                2'b10:   outst_r <= outst_r + OUTST_ONE;
                2'b01:   outst_r <= outst_r - OUTST_ONE;
                default: outst_r <= outst_r;
            endcase
        end
    end

    assign bus.inst_sram_addr_ok = addr_ok_s;
    assign bus.inst_sram_data_ok = data_ok_s;
    assign bus.inst_sram_rdata   = bus.rdata;
    assign bus.inst_sram_rerr    = data_ok_s && (bus.rresp != RESP_OKAY);
    assign bus.arid              = ARID;
    assign bus.araddr            = araddr_r;
    assign bus.arlen             = 8'd0;
    assign bus.arsize            = arsize_r;
    assign bus.arburst           = BURST_INCR;
    assign bus.arvalid           = (state_r == AR_BUSY);
    assign bus.rready            = rready_s;

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Scoreboard bench for inst_axi_bridge: stimulus pushes expected AR and R results,
// independent monitors pop and compare them whenever the DUT presents a handshake.
module tb_inst_axi_bridge;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [34:0] exp_ar_q[$];   // {arsize, araddr}
    logic [32:0] exp_r_q[$];    // {rerr, rdata}

    inst_axi_bridge_if bus();

    inst_axi_bridge #(.ARID(4'd0), .MAX_OUTST(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push_ar(input logic [31:0] addr, input logic [1:0] size);
        exp_ar_q.push_back({1'b0, size, addr});
    endtask

    task automatic beat(input logic [31:0] data, input logic [1:0] resp, input bit expect_ok);
        bus.rvalid = 1'b1;
        bus.rlast  = 1'b1;
        bus.rdata  = data;
        bus.rresp  = resp;
        if (expect_ok) exp_r_q.push_back({(resp != 2'b00), data});
    endtask

    task automatic idle_r();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
    endtask

    // AR monitor: every address handshake must match the next expected fetch.
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (bus.arvalid === 1'b1 && bus.arready === 1'b1) begin
                if (exp_ar_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL ar_unexpected: got araddr %0h expected no handshake", bus.araddr);
                end else begin
                    e = exp_ar_q.pop_front();
                    chk("ar_addr",  bus.araddr, e[31:0]);
                    chk("ar_size",  {29'd0, bus.arsize}, {29'd0, e[34:32]});
                    chk("ar_fixed", {20'd0, bus.arid, bus.arlen}, 32'd0);
                    chk("ar_burst", {30'd0, bus.arburst}, 32'd1);
                end
            end
        end
    end

    // R monitor: every data_ok must deliver the next expected instruction in order.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (bus.inst_sram_data_ok === 1'b1) begin
                if (exp_r_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL r_unexpected: got data_ok with rdata %0h expected none", bus.inst_sram_rdata);
                end else begin
                    e = exp_r_q.pop_front();
                    chk("r_data", bus.inst_sram_rdata, e[31:0]);
                    chk("r_err",  {31'd0, bus.inst_sram_rerr}, {31'd0, e[32]});
                end
            end else if (bus.inst_sram_rerr !== 1'b0) begin
                n_cmp++;
                n_err++;
                $display("FAIL r_err_idle: got rerr %0b expected 0", bus.inst_sram_rerr);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_wr   = 1'b0;
        bus.inst_sram_size = 2'd2;
        bus.inst_sram_addr = 32'h1c00_0000;
        bus.arready = 1'b0;
        bus.rid     = 4'd0;
        bus.rdata   = 32'd0;
        bus.rvalid  = 1'b1;
        bus.rlast   = 1'b1;
        bus.rresp   = 2'b00;

        // Reset: outputs forced even with req and rvalid high.
        repeat (3) begin
            step();
            smp();
            chk("rst_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
            chk("rst_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd0);
        end
        chk("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
        chk("rst_rready",  {31'd0, bus.rready}, 32'd1);
        chk("rst_araddr",  bus.araddr, 32'd0);
        chk("rst_arsize",  {29'd0, bus.arsize}, 32'd0);
        chk("rst_outst",   {30'd0, dut.outst_r}, 32'd0);
        step();
        reset = 1'b0;
        bus.inst_sram_req = 1'b0;
        idle_r();
        smp();
        chk("idle_no_ar", {31'd0, bus.arvalid}, 32'd0);

        // 1. Basic fetch.
        bus.arready = 1'b1;
        step();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h1c00_0000;
        push_ar(32'h1c00_0000, 2'd2);
        smp();
        chk("s1_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
        step();
        bus.inst_sram_req = 1'b0;
        smp();
        chk("s1_arvalid_t1", {31'd0, bus.arvalid}, 32'd1);
        step();
        smp();
        chk("s1_arvalid_t2", {31'd0, bus.arvalid}, 32'd0);
        step();
        beat(32'h0280_0c0c, 2'b00, 1'b1);
        step();
        idle_r();
        smp();
        chk("s1_outst", {30'd0, dut.outst_r}, 32'd0);

        // 2. AR stall: address held steady, no new acceptance while busy.
        bus.arready = 1'b0;
        step();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h1c00_0004;
        push_ar(32'h1c00_0004, 2'd2);
        smp();
        chk("s2_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
        step();
        bus.inst_sram_addr = 32'h1c00_0008;
        smp();
        for (int i = 0; i < 5; i++) begin
            chk("s2_stall_arvalid", {31'd0, bus.arvalid}, 32'd1);
            chk("s2_stall_araddr",  bus.araddr, 32'h1c00_0004);
            chk("s2_stall_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
            if (i < 4) begin
                step();
                smp();
            end
        end
        step();
        bus.arready = 1'b1;
        smp();
        chk("s2_hs_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
        step();
        push_ar(32'h1c00_0008, 2'd2);
        smp();
        chk("s2_second_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
        step();
        bus.inst_sram_req = 1'b0;
        step();
        beat(32'h1111_0001, 2'b00, 1'b1);
        step();
        beat(32'h1111_0002, 2'b00, 1'b1);
        step();
        idle_r();
        smp();
        chk("s2_outst", {30'd0, dut.outst_r}, 32'd0);

        // 3. Outstanding limit of two with R withheld.
        step();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h0000_0100;
        push_ar(32'h0000_0100, 2'd2);
        smp();
        chk("s3_ok1", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
        step();
        smp();
        chk("s3_busy1", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
        step();
        bus.inst_sram_addr = 32'h0000_0104;
        push_ar(32'h0000_0104, 2'd2);
        smp();
        chk("s3_ok2", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
        step();
        smp();
        chk("s3_busy2", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
        step();
        bus.inst_sram_addr = 32'h0000_0108;
        smp();
        for (int i = 0; i < 3; i++) begin
            chk("s3_full", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
            step();
            smp();
        end
        step();
        beat(32'h2222_0100, 2'b00, 1'b1);
        smp();
        chk("s3_beat_cycle", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
        step();
        idle_r();
        push_ar(32'h0000_0108, 2'd2);
        smp();
        chk("s3_ok3", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
        step();
        bus.inst_sram_req = 1'b0;
        step();
        beat(32'h2222_0104, 2'b00, 1'b1);
        step();
        beat(32'h2222_0108, 2'b00, 1'b1);
        step();
        idle_r();
        smp();
        chk("s3_outst", {30'd0, dut.outst_r}, 32'd0);

        // 4. Accept and last beat in the same cycle at outst=1.
        step();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h0000_0200;
        push_ar(32'h0000_0200, 2'd2);
        step();
        bus.inst_sram_req = 1'b0;
        step();
        smp();
        chk("s4_pre_outst", {30'd0, dut.outst_r}, 32'd1);
        step();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h0000_0204;
        push_ar(32'h0000_0204, 2'd2);
        beat(32'h3333_0200, 2'b00, 1'b1);
        smp();
        chk("s4_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
        step();
        bus.inst_sram_req = 1'b0;
        idle_r();
        smp();
        chk("s4_outst", {30'd0, dut.outst_r}, 32'd1);
        step();
        beat(32'h3333_0204, 2'b00, 1'b1);
        step();
        idle_r();

        // 5. Error response flagged for exactly its own cycle.
        step();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h0000_0300;
        bus.inst_sram_size = 2'd1;
        push_ar(32'h0000_0300, 2'd1);
        step();
        bus.inst_sram_req = 1'b0;
        step();
        beat(32'hdead_beef, 2'b10, 1'b1);
        smp();
        chk("s5_rerr", {31'd0, bus.inst_sram_rerr}, 32'd1);
        step();
        idle_r();
        smp();
        chk("s5_rerr_after", {31'd0, bus.inst_sram_rerr}, 32'd0);
        chk("s5_outst", {30'd0, dut.outst_r}, 32'd0);

        // Stray beat with nothing outstanding is swallowed.
        step();
        beat(32'h5555_aaaa, 2'b10, 1'b0);
        smp();
        chk("stray_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd0);
        step();
        idle_r();
        smp();
        chk("stray_outst", {30'd0, dut.outst_r}, 32'd0);

        // 6. Reset taken while the address is stalled in AR_BUSY.
        bus.arready = 1'b0;
        bus.inst_sram_size = 2'd2;
        step();
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h0000_0400;
        step();
        bus.inst_sram_req = 1'b0;
        smp();
        chk("s6_busy_arvalid", {31'd0, bus.arvalid}, 32'd1);
        chk("s6_busy_outst", {30'd0, dut.outst_r}, 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        smp();
        chk("s6_rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
        chk("s6_rst_outst", {30'd0, dut.outst_r}, 32'd0);
        step();
        bus.arready = 1'b1;
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = 32'h0000_0500;
        push_ar(32'h0000_0500, 2'd2);
        smp();
        chk("s6_post_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
        step();
        bus.inst_sram_req = 1'b0;
        step();
        beat(32'h6666_0500, 2'b00, 1'b1);
        step();
        idle_r();
        smp();
        chk("s6_outst", {30'd0, dut.outst_r}, 32'd0);

        repeat (3) step();
        smp();
        chk("ar_queue_drained", exp_ar_q.size(), 32'd0);
        chk("r_queue_drained",  exp_r_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
